clk_period_monitor: RTL

Measures the period of one divided clock from the clock generator (1 Hz, 2 Hz, fast or blink) in sys_clk cycles. It checks each period against an expected value and tolerance, tracks lock, and counts errors. It sits on the receiving side of the divider outputs and serves as the on-chip self-check and debug observer for the stopwatch clocking. One instance monitors one clock.

---
 rtl/clk_period_monitor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/clk_period_monitor.sv
`timescale 1ns/1ps
// clk_period_monitor: measures the period of one divided clock in sys_clk cycles,
// checks it against EXP_PERIOD +/- TOL, tracks lock and counts errors.
module clk_period_monitor #(
    parameter int EXP_PERIOD = 100_000_000,
    parameter int TOL        = 1000,
    parameter int LOCK_N     = 4,
    parameter int CNT_W      = 27
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             en,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_tol,
    output logic             locked,
    output logic             stuck,
    output logic [7:0]       err_cnt
);
    localparam int CMP_W = CNT_W + 1;
    localparam int LCK_W = $clog2(LOCK_N + 1);

    // One extra bit so HI+1 can never wrap back into range.
    localparam logic [CMP_W-1:0] HI       = CMP_W'(EXP_PERIOD + TOL);
    localparam logic [CMP_W-1:0] LO       = CMP_W'(EXP_PERIOD - TOL);
    localparam logic [CMP_W-1:0] LIMIT    = HI + CMP_W'(1);
    localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_N);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, LOST} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CMP_W-1:0] cnt_x;
    logic [LCK_W-1:0] lock_cnt, lock_inc;
    logic             report, timeout, recover;
    logic             rpt_ok, err_inc;

    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign cnt_x    = {1'b0, cnt};
    assign rpt_ok   = (cnt_x >= LO) && (cnt_x <= HI);
    assign lock_inc = (lock_cnt == LOCK_MAX) ? LOCK_MAX : lock_cnt + LCK_W'(1);
    assign err_inc  = timeout | (report & ~rpt_ok);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        state_nxt = state;
        report    = 1'b0;
        timeout   = 1'b0;
        recover   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (rise) state_nxt = ARM;
                ARM: begin
                    if (rise) begin
                        state_nxt = MEAS;
                    end else if (cnt_x == LIMIT) begin
                        timeout   = 1'b1;
                        state_nxt = LOST;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        report = 1'b1;
                    end else if (cnt_x == LIMIT) begin
                        timeout   = 1'b1;
                        state_nxt = LOST;
                    end
                end
                LOST: begin
                    if (rise) begin
                        recover   = 1'b1;
                        state_nxt = ARM;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lock_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            in_tol       <= 1'b0;
            locked       <= 1'b0;
            stuck        <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            period_valid <= report;

            if (report) begin
                period <= cnt;
                in_tol <= rpt_ok;
            end

            // Counter is held on the timeout edge and while IDLE or LOST.
            if (!en) begin
                cnt <= '0;
            end else if (rise) begin
                cnt <= CNT_W'(1);
            end else if ((state == ARM || state == MEAS) && !timeout) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (!en || timeout || (report && !rpt_ok)) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else if (report) begin
                lock_cnt <= lock_inc;
                locked   <= (lock_inc == LOCK_MAX);
            end

            if (timeout) begin
                stuck <= 1'b1;
            end else if (recover) begin
                stuck <= 1'b0;
            end

            if (clr_err) begin
                err_cnt <= '0;
            end else if (err_inc && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
